// File: rtl/mem_arb_pkg.sv
// Shared types for the round-robin memory arbiter: memory op encoding and arbiter FSM states.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10
    } mem_op_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: returns the first set request strictly after last_idx, with wrap-around.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_idx,
    output logic [IW-1:0] pick,
    output logic          any
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic           found;
    int unsigned    start;

    assign req_dbl = {req, req};
    assign any     = |req;

    // Rotating the doubled vector right by start puts the highest-priority source at bit 0.
    always_comb begin
        start   = (int'(last_idx) + 1) % N;
        req_rot = N'(req_dbl >> start);
        pick    = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                pick  = IW'((start + i) % N);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-way round-robin arbiter in front of a single mem_ctrl port; the grant is held from request
// through mem_tx_done, and only the granted source sees mem_ctrl responses.
module mem_arbiter_rr
    import mem_arb_pkg::*;
#(
    parameter int NUM_SRC    = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 512,
    parameter int OP_WIDTH   = 2,
    localparam int IW        = $clog2(NUM_SRC)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_SRC*OP_WIDTH-1:0]      op_src,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0]    raw_address_src,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0]    address_offset_src,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]    wr_data_src,
    output logic [NUM_SRC*DATA_WIDTH-1:0]    rd_data_src,
    output logic [NUM_SRC-1:0]               tx_done_src,
    output logic [NUM_SRC-1:0]               rd_valid_src,
    input  logic [DATA_WIDTH-1:0]            mem_rd_data,
    input  logic                             mem_tx_done,
    input  logic                             mem_rd_valid,
    output logic [OP_WIDTH-1:0]              mem_op,
    output logic [ADDR_WIDTH-1:0]            mem_raw_address,
    output logic [ADDR_WIDTH-1:0]            mem_address_offset,
    output logic [DATA_WIDTH-1:0]            mem_wr_data,
    output logic                             grant_valid,
    output logic [IW-1:0]                    grant_idx
);

    arb_state_t       state_q;
    logic             grant_valid_q;
    logic [IW-1:0]    grant_idx_q;
    logic [IW-1:0]    last_idx_q;
    logic [NUM_SRC-1:0] req;
    logic [IW-1:0]    pick;
    logic             any_req;
    logic             gnt_req;

    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            req[i] = |op_src[i*OP_WIDTH +: OP_WIDTH];
        end
    end

    assign gnt_req = req[grant_idx_q];

    rr_pick #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_pick (
        .req      (req),
        .last_idx (last_idx_q),
        .pick     (pick),
        .any      (any_req)
    );

    // Completion wins over abort when mem_tx_done coincides with the granted op dropping;
    // both leave BUSY, but only completion was ever a forwarded response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARB_IDLE;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            last_idx_q    <= IW'(NUM_SRC - 1);
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (any_req) begin
                        state_q       <= ARB_BUSY;
                        grant_valid_q <= 1'b1;
                        grant_idx_q   <= pick;
                        last_idx_q    <= pick;
                    end
                end
                ARB_BUSY: begin
                    if (mem_tx_done || !gnt_req) begin
                        state_q       <= ARB_IDLE;
                        grant_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= ARB_IDLE;
                    grant_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;

    // Everything keys off the registered grant, so reset silences mem_ctrl and all sources at once.
    always_comb begin
        mem_op             = '0;
        mem_raw_address    = '0;
        mem_address_offset = '0;
        mem_wr_data        = '0;
        rd_data_src        = '0;
        tx_done_src        = '0;
        rd_valid_src       = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_valid_q && (grant_idx_q == IW'(i))) begin
                mem_op             = op_src[i*OP_WIDTH +: OP_WIDTH];
                mem_raw_address    = raw_address_src[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_address_offset = address_offset_src[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wr_data        = wr_data_src[i*DATA_WIDTH +: DATA_WIDTH];
                rd_data_src[i*DATA_WIDTH +: DATA_WIDTH] = mem_rd_data;
                tx_done_src[i]     = mem_tx_done;
                rd_valid_src[i]    = mem_rd_valid;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed and randomized bench for mem_arbiter_rr against a cycle-level round-robin reference model.
module tb_mem_arbiter_rr;
    import mem_arb_pkg::*;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 512;
    localparam int OW = 2;
    localparam int IW = $clog2(N);

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic [OW-1:0] op  [N];
    logic [AW-1:0] raw [N];
    logic [AW-1:0] off [N];
    logic [DW-1:0] wd  [N];

    logic [N*OW-1:0] op_src;
    logic [N*AW-1:0] raw_address_src;
    logic [N*AW-1:0] address_offset_src;
    logic [N*DW-1:0] wr_data_src;
    logic [N*DW-1:0] rd_data_src;
    logic [N-1:0]    tx_done_src;
    logic [N-1:0]    rd_valid_src;
    logic [DW-1:0]   mem_rd_data;
    logic            mem_tx_done;
    logic            mem_rd_valid;
    logic [OW-1:0]   mem_op;
    logic [AW-1:0]   mem_raw_address;
    logic [AW-1:0]   mem_address_offset;
    logic [DW-1:0]   mem_wr_data;
    logic            grant_valid;
    logic [IW-1:0]   grant_idx;

    int total = 0;
    int bad   = 0;

    // Reference model: is a transaction in flight, who holds it, who won last.
    bit m_busy;
    int m_g;
    int m_last;

    int fair_exp [6] = '{0, 1, 2, 0, 1, 2};
    int skip_exp [3] = '{0, 2, 0};
    logic [DW-1:0] a5_line;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            op_src[i*OW +: OW]             = op[i];
            raw_address_src[i*AW +: AW]    = raw[i];
            address_offset_src[i*AW +: AW] = off[i];
            wr_data_src[i*DW +: DW]        = wd[i];
        end
    end

    mem_arbiter_rr #(
        .NUM_SRC    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .OP_WIDTH   (OW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .op_src             (op_src),
        .raw_address_src    (raw_address_src),
        .address_offset_src (address_offset_src),
        .wr_data_src        (wr_data_src),
        .rd_data_src        (rd_data_src),
        .tx_done_src        (tx_done_src),
        .rd_valid_src       (rd_valid_src),
        .mem_rd_data        (mem_rd_data),
        .mem_tx_done        (mem_tx_done),
        .mem_rd_valid       (mem_rd_valid),
        .mem_op             (mem_op),
        .mem_raw_address    (mem_raw_address),
        .mem_address_offset (mem_address_offset),
        .mem_wr_data        (mem_wr_data),
        .grant_valid        (grant_valid),
        .grant_idx          (grant_idx)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_busy = 1'b0;
        m_g    = 0;
        m_last = N - 1;
    endtask

    // Round-robin rule: first requester after the last winner, wrapping.
    task automatic model_step();
        int idx;
        if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (op[idx] != '0) begin
                    m_busy = 1'b1;
                    m_g    = idx;
                    m_last = idx;
                    break;
                end
            end
        end else if (mem_tx_done || op[m_g] == '0) begin
            m_busy = 1'b0;
        end
    endtask

    task automatic check_all();
        logic [N-1:0] e_tx;
        logic [N-1:0] e_rv;
        chk("grant_valid", grant_valid, m_busy);
        chk("grant_idx", grant_idx, m_g);
        chk("mem_op", mem_op, m_busy ? op[m_g] : '0);
        chk("mem_raw_address", mem_raw_address, m_busy ? raw[m_g] : '0);
        chk("mem_address_offset", mem_address_offset, m_busy ? off[m_g] : '0);
        chk("mem_wr_data", mem_wr_data, m_busy ? wd[m_g] : '0);
        e_tx = '0;
        e_rv = '0;
        for (int i = 0; i < N; i++) begin
            if (m_busy && m_g == i) begin
                e_tx[i] = mem_tx_done;
                e_rv[i] = mem_rd_valid;
            end
            chk($sformatf("rd_data_src%0d", i), rd_data_src[i*DW +: DW],
                (m_busy && m_g == i) ? mem_rd_data : '0);
        end
        chk("tx_done_src", tx_done_src, e_tx);
        chk("rd_valid_src", rd_valid_src, e_rv);
    endtask

    // One clock: check outputs mid-cycle, advance the model on the edge, return just after it.
    task automatic cyc();
        #2;
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) begin
            op[i]  = OP_NONE;
            raw[i] = '0;
            off[i] = '0;
            wd[i]  = '0;
        end
        mem_rd_data  = '0;
        mem_tx_done  = 1'b0;
        mem_rd_valid = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        m_reset();
        #2;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        a5_line = {64{8'hA5}};
        clear_inputs();
        m_reset();

        // Reset with every source requesting.
        for (int i = 0; i < N; i++) op[i] = OP_READ;
        #1 rst_n = 1'b0;
        #2;
        check_all();
        chk("rst_mem_op", mem_op, 0);
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_tx_done", tx_done_src, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cyc();
        chk("rst_first_grant_idx", grant_idx, 0);
        chk("rst_first_grant_valid", grant_valid, 1);

        // Single requester on src2.
        apply_reset();
        op[2]  = OP_READ;
        raw[2] = 32'h1000;
        off[2] = 32'h40;
        cyc();
        chk("single_mem_op", mem_op, 2'b01);
        chk("single_addr", mem_raw_address, 32'h1000);
        chk("single_offset", mem_address_offset, 32'h40);
        mem_rd_data  = a5_line;
        mem_rd_valid = 1'b1;
        mem_tx_done  = 1'b1;
        #2;
        chk("single_rd_data2", rd_data_src[2*DW +: DW], a5_line);
        chk("single_rd_data0", rd_data_src[0 +: DW], 0);
        chk("single_rd_data1", rd_data_src[DW +: DW], 0);
        chk("single_tx_done", tx_done_src, 3'b100);
        chk("single_rd_valid", rd_valid_src, 3'b100);
        cyc();
        clear_inputs();
        chk("single_back_idle", grant_valid, 0);
        cyc();

        // Fairness: all three hold WRITE, tx_done on the fourth busy cycle.
        apply_reset();
        for (int i = 0; i < N; i++) op[i] = OP_WRITE;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("fair_grant_idx", grant_idx, fair_exp[k]);
            chk("fair_grant_valid", grant_valid, 1);
            cyc();
            cyc();
            cyc();
            mem_tx_done = 1'b1;
            cyc();
            mem_tx_done = 1'b0;
            chk("fair_idle_gap", grant_valid, 0);
        end

        // Skip idle src1.
        apply_reset();
        op[0] = OP_WRITE;
        op[2] = OP_WRITE;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("skip_grant_idx", grant_idx, skip_exp[k]);
            chk("skip_grant_valid", grant_valid, 1);
            cyc();
            mem_tx_done = 1'b1;
            cyc();
            mem_tx_done = 1'b0;
            chk("skip_idle_gap", grant_valid, 0);
        end

        // Abort: src1 drops its op with no tx_done.
        apply_reset();
        op[1] = OP_READ;
        cyc();
        chk("abort_grant_idx", grant_idx, 1);
        cyc();
        cyc();
        op[1] = OP_NONE;
        cyc();
        chk("abort_idle", grant_valid, 0);
        mem_tx_done  = 1'b1;
        mem_rd_valid = 1'b1;
        #2;
        chk("abort_no_tx_done", tx_done_src, 0);
        chk("abort_no_rd_valid", rd_valid_src, 0);
        cyc();
        mem_tx_done  = 1'b0;
        mem_rd_valid = 1'b0;

        // Reset in the middle of a src1 READ.
        apply_reset();
        op[1] = OP_READ;
        cyc();
        chk("mid_grant_idx", grant_idx, 1);
        op[0] = OP_READ;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_op", mem_op, 0);
        chk("mid_rst_grant_valid", grant_valid, 0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cyc();
        chk("mid_after_grant_idx", grant_idx, 0);

        // Randomized traffic; the granted source holds its request stable or aborts.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (m_busy && m_g == i) begin
                    if ($urandom_range(0, 7) == 0) op[i] = OP_NONE;
                end else begin
                    op[i]  = OW'($urandom_range(0, 2));
                    raw[i] = $urandom;
                    off[i] = $urandom;
                    wd[i]  = {16{$urandom}};
                end
            end
            mem_tx_done  = ($urandom_range(0, 3) == 0);
            mem_rd_valid = 1'($urandom_range(0, 1));
            mem_rd_data  = {16{$urandom}};
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
